t05_codebook_walker: RTL and testbench
======================================

// Module: t05_codebook_walker
// PURPOSE
//  Parametrised codebook generator: walks a Huffman tree held in SRAM (one entry per internal node,
//  root at max_index) depth-first, left before right, and streams one {char, code, length} per leaf
//  over ready/valid. Successor to cb_synthesis; feeds header_synthesis / the encoder LUT. Adds an
//  explicit stack (no re-fetch on backtrack), variable-latency memory port, output backpressure, error flag.
// PARAMETERS
//  IDX_W     7    node index width; max_index in [0, 2**IDX_W-1]
//  CHAR_W    8    character width; child field = {is_node, CHAR_W bits}
//  SUM_W     46   frequency-sum field width (ignored by this block)
//  MAX_DEPTH 128  max code length = stack depth; LEN_W = $clog2(MAX_DEPTH+1)
//  Entry: ENTRY_W = IDX_W+2*(CHAR_W+1)+SUM_W = {max_idx, left, right, sum}, MSB first (71 b default).
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          async active-high reset
//  start      in   1          one-cycle pulse; ignored while busy
//  max_index  in   IDX_W      root index, latched on accepted start
//  mem_req    out  1          one-cycle read strobe
//  mem_addr   out  IDX_W      node index to read; stable until mem_valid
//  mem_valid  in   1          node_data valid (>=1 cycle after mem_req)
//  node_data  in   ENTRY_W    tree entry
//  code_valid out  1          leaf code available
//  code_ready in   1          consumer accepts when code_valid&code_ready
//  code_char  out  CHAR_W     leaf character
//  code_bits  out  MAX_DEPTH  bit i = branch at depth i+1 (0=left,1=right); bits >= code_len are 0
//  code_len   out  LEN_W      code length, 1..MAX_DEPTH
//  busy       out  1          high from accepted start until done
//  done       out  1          one-cycle pulse at end of walk
//  err        out  1          sticky until next start: overflow or bad pointer
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; depth=0; path=0; stack cleared.
//  States: IDLE, FETCH, WAIT, NODE, CHILD, EMIT, BACK, DONE.
//  IDLE: start -> latch max_index, cur=max_index, depth=0, path=0, err=0, busy=1 -> FETCH.
//  FETCH: mem_req=1 for one cycle, mem_addr=cur -> WAIT. WAIT: hold until mem_valid, latch entry -> NODE.
//  NODE: if depth==MAX_DEPTH -> err=1 -> DONE. Else push {right, side=0}, path[depth]=0, depth++,
//   child=left -> CHILD.
//  CHILD: child[CHAR_W]=0 -> leaf -> EMIT. Else if child idx > latched max_index -> err -> DONE;
//   else cur=child idx -> FETCH.
//  EMIT: code_valid=1, char/bits/len=depth held stable until code_ready; on handshake -> BACK.
//  BACK: depth==0 -> DONE. Top side==0: side=1, path[depth-1]=1, child=stored right -> CHILD.
//   Top side==1: pop, clear path[depth-1], depth-- -> BACK (one level per cycle).
//  DONE: done=1 one cycle, busy=0 -> IDLE.
//  Single-leaf tree: root right field == {1'b1, 8'h80} (null) -> left leaf emitted with code "0",
//   len 1; null right skipped in BACK.
//  Each node fetched exactly once. Emission order = left-first DFS leaf order.
//  start during busy ignored; rst mid-walk aborts immediately (no done), next start restarts.
//  code_valid never drops without handshake (except rst).
// TESTING
//  1 Single leaf: max_index=0, entry {0, {0,'d67}, {1,8'h80}, 0} -> one code C, bits "0", len 1; done.
//  2 9-node tree (root 8: 8->{6,7}, 6->{3,4}, 3->{0,'A'}, 0->{C,B}, 4->{F,G}, 7->{J,5}, 5->{1,2},
//    1->{D,E}, 2->{H,I}) -> order/codes (first bit first): C 0000, B 0001, A 001, F 010, G 011,
//    J 10, D 1100, E 1101, H 1110, I 1111; 9 mem_req total.
//  3 Test 2 with code_ready low 5 cycles per code and mem_valid latency 1..4 random -> identical output.
//  4 Chain tree depth 31 (node k={char, node k-1}) -> 31 codes, longest len 31; MAX_DEPTH=8 -> err=1, done.
//  5 Bad pointer: child idx 9 with max_index=8 -> err=1, done, no further mem_req.
//  6 rst asserted mid-walk in test 2, then restart -> all outputs 0 at once; full 10-code sequence again.

Source files
------------

// File: rtl/t05_codebook_walker.sv
// rtl/t05_codebook_walker.sv - depth-first Huffman codebook walker with explicit backtrack stack
module t05_codebook_walker #(
    parameter int IDX_W     = 7,
    parameter int CHAR_W    = 8,
    parameter int SUM_W     = 46,
    parameter int MAX_DEPTH = 128,
    parameter int LEN_W     = $clog2(MAX_DEPTH + 1),
    parameter int ENTRY_W   = IDX_W + 2 * (CHAR_W + 1) + SUM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     max_index,
    output logic                 mem_req,
    output logic [IDX_W-1:0]     mem_addr,
    input  logic                 mem_valid,
    input  logic [ENTRY_W-1:0]   node_data,
    output logic                 code_valid,
    input  logic                 code_ready,
    output logic [CHAR_W-1:0]    code_char,
    output logic [MAX_DEPTH-1:0] code_bits,
    output logic [LEN_W-1:0]     code_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CF_W  = CHAR_W + 1;
    localparam int SP_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int CMP_W = (CHAR_W > IDX_W) ? CHAR_W : IDX_W;
    localparam logic [CF_W-1:0] NULL_CHILD = {2'b11, {(CHAR_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, NODE, CHILD, EMIT, BACK, DONE
    } state_t;

    state_t               state, state_nx;
    logic [IDX_W-1:0]     max_lat;
    logic [IDX_W-1:0]     cur;
    logic [LEN_W-1:0]     depth;
    logic [MAX_DEPTH-1:0] path;
    logic [MAX_DEPTH-1:0] stk_side;
    logic [CF_W-1:0]      stk_right [MAX_DEPTH];
    logic [CF_W-1:0]      ent_left;
    logic [CF_W-1:0]      ent_right;
    logic [CF_W-1:0]      child;
    logic                 err_r;

    logic [SP_W-1:0]      dep_sp;
    logic [SP_W-1:0]      top_sp;
    logic                 at_max;
    logic                 child_node;
    logic                 child_bad;
    logic                 top_open;
    logic                 unused_fields;

    assign dep_sp     = depth[SP_W-1:0];
    assign top_sp     = dep_sp - 1'b1;
    assign at_max     = (depth == LEN_W'(MAX_DEPTH));
    assign child_node = child[CHAR_W];
    assign child_bad  = CMP_W'(child[CHAR_W-1:0]) > CMP_W'(max_lat);
    // A null right sibling (single-leaf tree) is treated as already visited.
    assign top_open   = !stk_side[top_sp] && (stk_right[top_sp] != NULL_CHILD);

    assign unused_fields = ^{node_data[ENTRY_W-1:ENTRY_W-IDX_W], node_data[SUM_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        code_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                busy     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_valid) state_nx = NODE;
            end
            NODE: begin
                busy     = 1'b1;
                state_nx = at_max ? DONE : CHILD;
            end
            CHILD: begin
                busy = 1'b1;
                if (!child_node)    state_nx = EMIT;
                else if (child_bad) state_nx = DONE;
                else                state_nx = FETCH;
            end
            EMIT: begin
                busy       = 1'b1;
                code_valid = 1'b1;
                if (code_ready) state_nx = BACK;
            end
            BACK: begin
                busy = 1'b1;
                if (depth == '0)   state_nx = DONE;
                else if (top_open) state_nx = CHILD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_lat   <= '0;
            cur       <= '0;
            depth     <= '0;
            path      <= '0;
            stk_side  <= '0;
            ent_left  <= '0;
            ent_right <= '0;
            child     <= '0;
            err_r     <= 1'b0;
            for (int i = 0; i < MAX_DEPTH; i++) stk_right[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    max_lat <= max_index;
                    cur     <= max_index;
                    depth   <= '0;
                    path    <= '0;
                    err_r   <= 1'b0;
                end
                WAIT: if (mem_valid) begin
                    ent_left  <= node_data[SUM_W + 2*CF_W - 1 : SUM_W + CF_W];
                    ent_right <= node_data[SUM_W + CF_W - 1 : SUM_W];
                end
                NODE: if (at_max) begin
                    err_r <= 1'b1;
                end else begin
                    stk_right[dep_sp] <= ent_right;
                    stk_side[dep_sp]  <= 1'b0;
                    path[dep_sp]      <= 1'b0;
                    depth             <= depth + 1'b1;
                    child             <= ent_left;
                end
                CHILD: if (child_node) begin
                    if (child_bad) err_r <= 1'b1;
                    else           cur   <= child[IDX_W-1:0];
                end
                BACK: if (depth != '0) begin
                    if (top_open) begin
                        stk_side[top_sp] <= 1'b1;
                        path[top_sp]     <= 1'b1;
                        child            <= stk_right[top_sp];
                    end else begin
                        path[top_sp] <= 1'b0;
                        depth        <= depth - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = cur;
    assign code_char = child[CHAR_W-1:0];
    assign code_bits = path;
    assign code_len  = depth;
    assign err       = err_r;

endmodule

// File: tb/tb_t05_codebook_walker.sv
// tb/tb_t05_codebook_walker.sv - directed bench for the codebook walker
module tb_t05_codebook_walker;
    localparam int EW = 71;
    localparam logic [8:0] NUL = {1'b1, 8'h80};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic [6:0] max_index = '0;

    logic mem_req, mem_valid;
    logic [6:0] mem_addr;
    logic [EW-1:0] node_data;
    logic code_valid, code_ready;
    logic [7:0] code_char;
    logic [127:0] code_bits;
    logic [7:0] code_len;
    logic busy, done, err;

    logic mem_req2, mem_valid2;
    logic [6:0] mem_addr2;
    logic [EW-1:0] node_data2;
    logic code_valid2;
    logic [7:0] code_char2;
    logic [7:0] code_bits2;
    logic [3:0] code_len2;
    logic busy2, done2, err2;

    logic [EW-1:0] mem [128];
    int total = 0;
    int bad = 0;
    bit lat_rand = 1'b0;
    bit bp = 1'b0;
    int req_cnt = 0, req2_cnt = 0, n_codes = 0, n_codes2 = 0, unstable = 0;
    int lat_cnt, hold;
    bit pend;
    logic pv_stall;
    logic [7:0] pv_ch, pv_len;
    logic [127:0] pv_bits;
    logic [7:0] g_ch [256];
    logic [127:0] g_bits [256];
    logic [7:0] g_len [256];
    logic [3:0] g_len2 [32];

    logic [7:0] e_ch [10] = '{"C", "B", "A", "F", "G", "J", "D", "E", "H", "I"};
    logic [7:0] e_p [10] = '{8'b0000, 8'b0001, 8'b001, 8'b010, 8'b011,
                             8'b10, 8'b1100, 8'b1101, 8'b1110, 8'b1111};
    int e_n [10] = '{4, 4, 3, 3, 3, 2, 4, 4, 4, 4};

    t05_codebook_walker dut (
        .clk(clk), .rst(rst), .start(start), .max_index(max_index),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .node_data(node_data),
        .code_valid(code_valid), .code_ready(code_ready), .code_char(code_char),
        .code_bits(code_bits), .code_len(code_len), .busy(busy), .done(done), .err(err)
    );

    t05_codebook_walker #(.MAX_DEPTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .max_index(max_index),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_valid(mem_valid2), .node_data(node_data2),
        .code_valid(code_valid2), .code_ready(1'b1), .code_char(code_char2),
        .code_bits(code_bits2), .code_len(code_len2), .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    // Memory model with optional random read latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            lat_cnt   <= 0;
            mem_valid <= 1'b0;
            node_data <= '0;
        end else begin
            mem_valid <= 1'b0;
            if (mem_req) begin
                pend    <= 1'b1;
                lat_cnt <= lat_rand ? int'($urandom_range(3, 0)) : 0;
                req_cnt <= req_cnt + 1;
            end else if (pend) begin
                if (lat_cnt == 0) begin
                    mem_valid <= 1'b1;
                    node_data <= mem[mem_addr];
                    pend      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid2 <= 1'b0;
            node_data2 <= '0;
        end else begin
            mem_valid2 <= mem_req2;
            node_data2 <= mem[mem_addr2];
            if (mem_req2) req2_cnt <= req2_cnt + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) hold <= 0;
        else if (code_valid && !code_ready) hold <= hold + 1;
        else hold <= 0;
    end
    assign code_ready = !bp || (hold >= 5);

    always @(posedge clk) begin
        if (pv_stall === 1'b1 && !rst &&
            (!code_valid || code_char !== pv_ch || code_bits !== pv_bits || code_len !== pv_len))
            unstable <= unstable + 1;
        pv_stall <= code_valid && !code_ready;
        pv_ch    <= code_char;
        pv_bits  <= code_bits;
        pv_len   <= code_len;
        if (code_valid && code_ready && n_codes < 256) begin
            g_ch[n_codes]   <= code_char;
            g_bits[n_codes] <= code_bits;
            g_len[n_codes]  <= code_len;
            n_codes         <= n_codes + 1;
        end
        if (code_valid2 && n_codes2 < 32) begin
            g_len2[n_codes2] <= code_len2;
            n_codes2         <= n_codes2 + 1;
        end
    end

    function automatic logic [8:0] nd(input int i);
        return {1'b1, 8'(i)};
    endfunction

    function automatic logic [8:0] lf(input logic [7:0] c);
        return {1'b0, c};
    endfunction

    function automatic logic [EW-1:0] mk(input logic [8:0] l, input logic [8:0] r);
        return {7'h55, l, r, 46'h1234};
    endfunction

    function automatic logic [127:0] fb(input logic [7:0] p, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = p[n-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [6:0] root, input bit second);
        @(negedge clk);
        max_index = root;
        if (second) start2 = 1'b1;
        else        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit second);
        int n;
        n = 0;
        while (((second ? done2 : done) !== 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 128'(n < 20000), 128'd1);
    endtask

    task automatic load_tree2();
        mem[8] = mk(nd(6), nd(7));
        mem[6] = mk(nd(3), nd(4));
        mem[3] = mk(nd(0), lf("A"));
        mem[0] = mk(lf("C"), lf("B"));
        mem[4] = mk(lf("F"), lf("G"));
        mem[7] = mk(lf("J"), nd(5));
        mem[5] = mk(nd(1), nd(2));
        mem[1] = mk(lf("D"), lf("E"));
        mem[2] = mk(lf("H"), lf("I"));
    endtask

    task automatic check_tree2(input string tag, input int base);
        chk({tag, " count"}, 128'(n_codes - base), 128'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s char%0d", tag, i), 128'(g_ch[base+i]), 128'(e_ch[i]));
            chk($sformatf("%s bits%0d", tag, i), g_bits[base+i], fb(e_p[i], e_n[i]));
            chk($sformatf("%s len%0d", tag, i), 128'(g_len[base+i]), 128'(e_n[i]));
        end
    endtask

    initial begin
        int base, rb, n;
        repeat (3) @(negedge clk);
        chk("rst ctl", 128'({mem_req, code_valid, busy, done, err}), 128'd0);
        chk("rst addr", 128'(mem_addr), 128'd0);
        chk("rst char", 128'(code_char), 128'd0);
        chk("rst len", 128'(code_len), 128'd0);
        chk("rst bits", code_bits, 128'd0);
        rst = 1'b0;

        // single leaf with null right sibling
        mem[0] = mk(lf("C"), NUL);
        base = n_codes; rb = req_cnt;
        pulse_start(7'd0, 1'b0);
        wait_done("t1", 1'b0);
        chk("t1 busy", 128'(busy), 128'd0);
        chk("t1 err", 128'(err), 128'd0);
        chk("t1 count", 128'(n_codes - base), 128'd1);
        chk("t1 char", 128'(g_ch[base]), 128'h43);
        chk("t1 bits", g_bits[base], 128'd0);
        chk("t1 len", 128'(g_len[base]), 128'd1);
        chk("t1 reqs", 128'(req_cnt - rb), 128'd1);

        // 9-node tree
        load_tree2();
        base = n_codes; rb = req_cnt;
        pulse_start(7'd8, 1'b0);
        wait_done("t2", 1'b0);
        chk("t2 err", 128'(err), 128'd0);
        chk("t2 reqs", 128'(req_cnt - rb), 128'd9);
        check_tree2("t2", base);

        // backpressure, random latency, and a start while busy
        lat_rand = 1'b1; bp = 1'b1;
        base = n_codes; rb = req_cnt;
        pulse_start(7'd8, 1'b0);
        repeat (20) @(negedge clk);
        max_index = 7'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3", 1'b0);
        chk("t3 err", 128'(err), 128'd0);
        chk("t3 reqs", 128'(req_cnt - rb), 128'd9);
        chk("t3 stable", 128'(unstable), 128'd0);
        check_tree2("t3", base);
        lat_rand = 1'b0; bp = 1'b0;

        // chain of 31 nodes, deepest leaf at length 31
        for (int k = 0; k < 31; k++)
            mem[k] = mk(lf(8'h20 + 8'(k)), (k == 0) ? NUL : nd(k - 1));
        base = n_codes; rb = req_cnt;
        pulse_start(7'd30, 1'b0);
        wait_done("t4", 1'b0);
        chk("t4 err", 128'(err), 128'd0);
        chk("t4 count", 128'(n_codes - base), 128'd31);
        chk("t4 reqs", 128'(req_cnt - rb), 128'd31);
        for (int j = 0; j < 31; j++) begin
            chk($sformatf("t4 len%0d", j), 128'(g_len[base+j]), 128'(j + 1));
            chk($sformatf("t4 bits%0d", j), g_bits[base+j], (128'd1 << j) - 128'd1);
            chk($sformatf("t4 char%0d", j), 128'(g_ch[base+j]), 128'(8'h20 + 8'(30 - j)));
        end

        // same chain against an 8-deep stack
        base = n_codes2; rb = req2_cnt;
        pulse_start(7'd30, 1'b1);
        wait_done("t4b", 1'b1);
        chk("t4b err", 128'(err2), 128'd1);
        chk("t4b busy", 128'(busy2), 128'd0);
        chk("t4b count", 128'(n_codes2 - base), 128'd8);
        chk("t4b reqs", 128'(req2_cnt - rb), 128'd9);
        for (int j = 0; j < 8; j++)
            chk($sformatf("t4b len%0d", j), 128'(g_len2[base+j]), 128'(j + 1));

        // child index beyond the root index
        mem[8] = mk(lf("X"), nd(9));
        base = n_codes; rb = req_cnt;
        pulse_start(7'd8, 1'b0);
        wait_done("t5", 1'b0);
        chk("t5 err", 128'(err), 128'd1);
        chk("t5 count", 128'(n_codes - base), 128'd1);
        chk("t5 char", 128'(g_ch[base]), 128'h58);
        repeat (10) @(negedge clk);
        chk("t5 reqs", 128'(req_cnt - rb), 128'd1);
        chk("t5 err sticky", 128'(err), 128'd1);

        // reset mid-walk, then a clean restart
        load_tree2();
        base = n_codes;
        pulse_start(7'd8, 1'b0);
        chk("t6 err cleared", 128'(err), 128'd0);
        n = 0;
        while (n_codes < base + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6 midwalk", 128'(n < 2000), 128'd1);
        rst = 1'b1;
        #1;
        chk("t6 rst ctl", 128'({mem_req, code_valid, busy, done, err}), 128'd0);
        chk("t6 rst data", 128'({mem_addr, code_char, code_len}), 128'd0);
        chk("t6 rst bits", code_bits, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        base = n_codes; rb = req_cnt;
        pulse_start(7'd8, 1'b0);
        wait_done("t6", 1'b0);
        chk("t6 reqs", 128'(req_cnt - rb), 128'd9);
        check_tree2("t6", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
